delay_timer: RTL
================

Name: delay_timer

Overview:
- Programmable delay / timeout generator for the reaction-meter datapath.
- Next generation of the single-mode trigger-to-timeout delay:
  - width is parameterised,
  - adds one-shot, retriggerable and periodic modes,
  - adds a configurable output pulse length, a synchronous abort, and busy / remaining-count status.
- Sits between the trigger/stimulus logic and the reaction-time counter; `time_out` marks expiry of the programmed delay.

Parameters:
- WIDTH, 14, width of the delay count `N` and of `count_out`.
- PULSE_LEN, 1, cycles `time_out` stays high per expiry; must be >= 1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- trigger  input  1  start request; rising edge (sampled) starts a delay.
- abort  input  1  synchronous cancel, highest priority.
- mode  input  2  00 one-shot, 01 retriggerable, 10 periodic, 11 treated as 00.
- N  input  WIDTH  delay length in cycles; sampled at start and at reload.
- time_out  output  1  registered expiry pulse, PULSE_LEN cycles wide.
- busy  output  1  high whenever state != IDLE.
- count_out  output  WIDTH  remaining count while COUNTING, else 0.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, count=0, pulse counter=0, time_out=0;
  - trig_d=1, so a trigger already held high at reset release is not a rising edge.
- Edge detect: `rise = trigger & ~trig_d`; trig_d is updated every cycle in every state.
- mode and N are latched into mode_q / n_q on each start; mid-delay changes on the inputs have no effect until the next start or reload.
- States: IDLE, COUNTING, PULSE, WAIT_LOW.
- IDLE:
  - `rise` and N != 0: latch mode/N, count <= N-1, go to COUNTING.
  - `rise` and N == 0: request is dropped, stay IDLE, no pulse.
- COUNTING:
  - count == 0: go to PULSE, set time_out=1, pulse counter <= PULSE_LEN-1.
  - Otherwise count decrements by 1.
  - mode_q==01 and `rise`: count <= N-1 (live N, re-latched); that reload takes priority over expiry in the same cycle.
  - N == 0 on a retrigger: the retrigger is ignored.
- Latency: with `rise` sampled at edge k, time_out is 1 from edge k+N for exactly PULSE_LEN cycles.
- PULSE:
  - Pulse counter decrements; `rise` is ignored.
  - On pulse counter == 0, time_out <= 0 and:
    - mode_q==10 with trigger high: count <= n_q-1, go to COUNTING (period = N + PULSE_LEN cycles).
    - otherwise, trigger high: go to WAIT_LOW.
    - otherwise: go to IDLE.
- WAIT_LOW: trigger == 0 → IDLE. This guarantees one expiry per trigger assertion in one-shot and retrig modes.
- Periodic stop: trigger low at end of PULSE ends the sequence (→ IDLE). Trigger dropping during COUNTING does not cancel the pending expiry.
- abort=1 at any edge:
  - next state IDLE, time_out=0, count=0, pulse counter=0;
  - wins over a simultaneous `rise`, expiry or reload.
- Wrap-around: count never underflows; N = 2^WIDTH-1 gives the maximum delay.
- Asynchronous reset mid-operation clears immediately; no pulse is emitted.

Test Plan:
- One-shot:
  - Stimulus: mode=00, N=5, PULSE_LEN=1; trigger rises at edge 10 and is held 20 cycles.
  - Required: time_out high on edge 15 only; busy 1 from edge 10 until trigger low; no second pulse.
- Retrigger:
  - Stimulus: mode=01, N=8; rises at edges 0 and 5.
  - Required: single pulse at edge 13, none at 8; count_out reads 7 at edge 5.
- Periodic:
  - Stimulus: mode=10, N=4, PULSE_LEN=2; trigger held high from edge 0.
  - Required: time_out high on edges 4-5, 10-11, 16-17.
  - Then: trigger dropped at edge 18 → IDLE after the pulse at 22-23.
- Abort:
  - Stimulus: mode=00, N=10, start at edge 0; abort at edge 6.
  - Required: busy=0 and count_out=0 after edge 6; no pulse.
  - Stimulus: abort coincident with `rise` in IDLE.
  - Required: stays IDLE.
- Boundaries:
  - N=0 with `rise` → no activity.
  - N=1 → pulse at edge k+1.
  - Trigger high through reset release → no start until trigger goes low then high.
- Reset mid-count: rst_n pulsed low at count=3 → all outputs 0 asynchronously; idle afterwards.

Source files
------------

// File: rtl/delay_timer.sv
// Programmable delay / timeout generator: one-shot, retriggerable and periodic
// modes with a configurable expiry pulse length and a synchronous abort.
module delay_timer #(
  parameter int WIDTH     = 14,
  parameter int PULSE_LEN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             trigger,
  input  logic             abort,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] N,
  output logic             time_out,
  output logic             busy,
  output logic [WIDTH-1:0] count_out
);

  localparam int PW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
  localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_LEN - 1);

  localparam logic [1:0] MODE_RETRIG   = 2'b01;
  localparam logic [1:0] MODE_PERIODIC = 2'b10;

  typedef enum logic [1:0] {IDLE, COUNTING, PULSE, WAIT_LOW} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [PW-1:0]    pcnt_q, pcnt_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic             trig_q, trig_d;
  logic             time_out_q, time_out_d;
  logic             rise;
  logic             n_nonzero;

  assign rise      = trigger & ~trig_q;
  assign n_nonzero = (N != '0);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    pcnt_d     = pcnt_q;
    mode_d     = mode_q;
    n_d        = n_q;
    trig_d     = trigger;
    time_out_d = time_out_q;

    case (state_q)
      IDLE: begin
        if (rise && n_nonzero) begin
          mode_d  = mode;
          n_d     = N;
          count_d = N - WIDTH'(1);
          state_d = COUNTING;
        end
      end
      COUNTING: begin
        // A retrigger reload beats an expiry landing in the same cycle.
        if (mode_q == MODE_RETRIG && rise && n_nonzero) begin
          n_d     = N;
          count_d = N - WIDTH'(1);
        end else if (count_q == '0) begin
          state_d    = PULSE;
          time_out_d = 1'b1;
          pcnt_d     = PULSE_LAST;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
      PULSE: begin
        if (pcnt_q == '0) begin
          time_out_d = 1'b0;
          if (mode_q == MODE_PERIODIC && trigger) begin
            count_d = n_q - WIDTH'(1);
            state_d = COUNTING;
          end else if (trigger) begin
            state_d = WAIT_LOW;
          end else begin
            state_d = IDLE;
          end
        end else begin
          pcnt_d = pcnt_q - PW'(1);
        end
      end
      WAIT_LOW: begin
        if (!trigger) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d    = IDLE;
      time_out_d = 1'b0;
      count_d    = '0;
      pcnt_d     = '0;
    end
  end

  // trig_q resets high so a trigger held through reset release is not an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      pcnt_q     <= '0;
      mode_q     <= '0;
      n_q        <= '0;
      trig_q     <= 1'b1;
      time_out_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      pcnt_q     <= pcnt_d;
      mode_q     <= mode_d;
      n_q        <= n_d;
      trig_q     <= trig_d;
      time_out_q <= time_out_d;
    end
  end

  assign time_out  = time_out_q;
  assign busy      = (state_q != IDLE);
  assign count_out = (state_q == COUNTING) ? count_q : '0;

endmodule
